pt_checker: RTL



---
 rtl/arc4_pkg.sv | 27 ++
 rtl/pt_checker.sv | 78 +++++++
 2 files changed

// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 crack loop.
// Plaintext checker FSM states and printable-range helper.
package arc4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_ISSUE,
    LEN_CAP,
    BYTE_ISSUE,
    BYTE_CAP,
    DONE
  } chk_state_t;

  localparam int PT_LEN_ADDR = 0;

  localparam logic [7:0] ASCII_LO_DEF = 8'h20;
  localparam logic [7:0] ASCII_HI_DEF = 8'h7E;

  function automatic logic is_printable(
    input logic [7:0] b,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/pt_checker.sv
// Scans a length-prefixed plaintext buffer and reports
// whether every message byte lies in the printable range.
module pt_checker
  import arc4_pkg::*;
#(
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] ASCII_LO = ASCII_LO_DEF,
  parameter logic [7:0] ASCII_HI = ASCII_HI_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic [ADDR_W-1:0] pt_addr,
  input  logic [7:0]        pt_rddata,
  output logic              valid,
  output logic [7:0]        fail_idx
);

  chk_state_t state;
  logic [7:0] len;
  logic [7:0] idx;

  assign rdy = (state == IDLE) || (state == DONE);

  // pt_addr is loaded on entry to each ISSUE state and held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= 1'b0;
      fail_idx <= 8'd0;
      pt_addr  <= '0;
      len      <= 8'd0;
      idx      <= 8'd0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (en) begin
            state    <= LEN_ISSUE;
            valid    <= 1'b0;
            fail_idx <= 8'd0;
            pt_addr  <= ADDR_W'(PT_LEN_ADDR);
          end
        end
        LEN_ISSUE: state <= LEN_CAP;
        LEN_CAP: begin
          len <= pt_rddata;
          idx <= 8'd1;
          if (pt_rddata == 8'd0) begin
            valid <= 1'b1;
            state <= DONE;
          end else begin
            pt_addr <= ADDR_W'(1);
            state   <= BYTE_ISSUE;
          end
        end
        BYTE_ISSUE: state <= BYTE_CAP;
        BYTE_CAP: begin
          if (!is_printable(pt_rddata, ASCII_LO, ASCII_HI)) begin
            valid    <= 1'b0;
            fail_idx <= idx;
            state    <= DONE;
          end else if (idx == len) begin
            valid    <= 1'b1;
            fail_idx <= 8'd0;
            state    <= DONE;
          end else begin
            idx     <= idx + 8'd1;
            pt_addr <= ADDR_W'(idx + 8'd1);
            state   <= BYTE_ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
